// File: rtl/dlx_pkg.sv
// dlx_pkg: shared DLX constants and the DMEM dump engine state type
//   DMEM_BASE   - first byte address of data memory
//   HALT_OPCODE - instruction word whose retirement raises halt
//   dump_state_t - dump engine FSM states
package dlx_pkg;
    localparam logic [31:0] DMEM_BASE   = 32'h0000_2000;
    localparam logic [31:0] HALT_OPCODE = 32'h4400_0300;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, DONE} dump_state_t;
endpackage

// File: rtl/dmem_dump_engine.sv
// dmem_dump_engine: after halt, streams COUNT DMEM bytes from BASE_ADDR to a ready/valid sink
//   clk, rst_n            - clock, asynchronous active-low reset
//   halt                  - level from the pipeline once the halt trap retires
//   mem_rd, mem_addr      - one-cycle byte read request to DMEM
//   mem_rdata             - DMEM byte, valid the cycle after mem_rd
//   out_data, out_valid   - dumped byte and its valid, held until out_ready
//   out_ready             - sink accepts out_data
//   busy, pipe_stall      - dump in progress / pipeline freeze (identical)
//   done                  - dump complete, sticky until reset
//   checksum              - 16-bit running sum of dumped bytes
module dmem_dump_engine
    import dlx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DMEM_BASE,
    parameter int          COUNT     = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        pipe_stall,
    output logic        done,
    output logic [15:0] checksum
);
    dump_state_t state, state_nxt;
    logic [15:0] index;
    logic        last;

    assign last = index == 16'(COUNT - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // halt is only looked at in IDLE, so re-assertion while busy or done is harmless
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (halt) state_nxt = COUNT == 0 ? DONE : REQ;
            REQ:     state_nxt = WAIT;
            WAIT:    state_nxt = SEND;
            SEND:    if (out_ready) state_nxt = last ? DONE : REQ;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            index    <= '0;
            checksum <= '0;
            out_data <= '0;
        end else begin
            if (state == IDLE && halt) begin
                index    <= '0;
                checksum <= '0;
            end
            if (state == WAIT) begin
                out_data <= mem_rdata;
                checksum <= checksum + {8'h00, mem_rdata};
            end
            if (state == SEND && out_ready && !last) index <= index + 16'd1;
        end

    always_comb begin
        mem_rd     = state == REQ;
        mem_addr   = mem_rd ? BASE_ADDR + {16'h0000, index} : '0;
        out_valid  = state == SEND;
        busy       = mem_rd || state == WAIT || out_valid;
        pipe_stall = busy;
        done       = state == DONE;
    end
endmodule

// File: tb/tb_dmem_dump_engine.sv
// tb_dmem_dump_engine: five engine configurations driven with directed and random ready/halt traffic
module tb_dmem_dump_engine;
    localparam int          N = 5;
    localparam int          CNT [N] = '{4, 100, 0, 200, 4};
    localparam logic [31:0] BA  [N] = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'hFFFF_FFFE};

    logic        clk = 0;
    logic        rst_n = 0;
    logic        halt [N];
    logic        out_ready [N];
    logic        mem_rd [N];
    logic [31:0] mem_addr [N];
    logic [7:0]  mem_rdata [N];
    logic [7:0]  out_data [N];
    logic        out_valid [N];
    logic        busy [N];
    logic        pipe_stall [N];
    logic        done [N];
    logic [15:0] checksum [N];

    logic [7:0]  mem [N][256];
    logic [7:0]  got [N][$];
    int          hs [N][$];
    int          rdcnt [N];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : gi
        logic       pv = 0, prd = 0, pdone = 0;
        logic [7:0] pd = 0;
        dmem_dump_engine #(.BASE_ADDR(BA[g]), .COUNT(CNT[g])) u_dut (
            .clk(clk), .rst_n(rst_n), .halt(halt[g]),
            .mem_rd(mem_rd[g]), .mem_addr(mem_addr[g]), .mem_rdata(mem_rdata[g]),
            .out_data(out_data[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .busy(busy[g]), .pipe_stall(pipe_stall[g]), .done(done[g]), .checksum(checksum[g])
        );
        // memory answers one cycle after a read; garbage otherwise
        always @(posedge clk)
            mem_rdata[g] <= mem_rd[g] ? mem[g][mem_addr[g][7:0] - BA[g][7:0]] : 8'($urandom);
        always @(negedge clk) begin
            if (!rst_n) begin
                chk("rd_in_reset", g, mem_rd[g], 0);
                chk("valid_in_reset", g, out_valid[g], 0);
                got[g].delete();
                hs[g].delete();
                pv = 0; prd = 0; pdone = 0;
            end else begin
                chk("stall_eq_busy", g, pipe_stall[g], busy[g]);
                if (mem_rd[g]) begin
                    chk("mem_addr", g, mem_addr[g], BA[g] + 32'(got[g].size()));
                    chk("rd_one_cycle", g, prd, 0);
                    rdcnt[g]++;
                end else chk("addr_idle", g, mem_addr[g], 0);
                if (pv) begin
                    chk("valid_hold", g, out_valid[g], 1);
                    chk("data_hold", g, out_data[g], pd);
                end
                if (pdone) chk("done_sticky", g, done[g], 1);
                if (out_valid[g] && out_ready[g]) begin
                    got[g].push_back(out_data[g]);
                    hs[g].push_back(cyc);
                end
                pv = out_valid[g] && !out_ready[g];
                pd = out_data[g];
                prd = mem_rd[g];
                pdone = done[g];
            end
        end
    end

    task automatic zero_check(input int k);
        chk("z_mem_rd", k, mem_rd[k], 0);
        chk("z_mem_addr", k, mem_addr[k], 0);
        chk("z_out_data", k, out_data[k], 0);
        chk("z_out_valid", k, out_valid[k], 0);
        chk("z_busy", k, busy[k], 0);
        chk("z_pipe_stall", k, pipe_stall[k], 0);
        chk("z_done", k, done[k], 0);
        chk("z_checksum", k, checksum[k], 0);
    endtask

    // mode 0: ready always high, 1: one high then two low, 2: random
    task automatic run(input int k, input int mode, input bit noise, input int budget);
        int c = 0;
        @(posedge clk); #1;
        halt[k] = 1;
        out_ready[k] = 1;
        while (!done[k] && c < budget) begin
            @(posedge clk); #1;
            halt[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready[k] = mode == 0 ? 1'b1 : mode == 1 ? 1'(c % 3 == 0) : 1'($urandom_range(0, 1));
            c++;
        end
        halt[k] = 0;
        out_ready[k] = 0;
        chk("timeout", k, 32'(c < budget), 1);
    endtask

    task automatic check_seq(input int k);
        int sum = 0;
        chk("byte_count", k, got[k].size(), CNT[k]);
        for (int i = 0; i < CNT[k]; i++) begin
            sum = (sum + int'(mem[k][i])) % 65536;
            if (i < got[k].size()) chk("byte", k, got[k][i], mem[k][i]);
        end
        chk("checksum", k, checksum[k], sum);
        chk("done", k, done[k], 1);
    endtask

    task automatic idle_halt(input int k);
        int n = got[k].size();
        int r = rdcnt[k];
        @(posedge clk); #1;
        halt[k] = 1;
        out_ready[k] = 1;
        repeat (10) @(posedge clk);
        #1;
        halt[k] = 0;
        out_ready[k] = 0;
        chk("no_restart_bytes", k, got[k].size(), n);
        chk("no_restart_reads", k, rdcnt[k], r);
        chk("done_held", k, done[k], 1);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            halt[k] = 0;
            out_ready[k] = 0;
            rdcnt[k] = 0;
            for (int i = 0; i < 256; i++)
                mem[k][i] = k == 0 ? 8'(i + 1) : k == 3 ? 8'hFF : 8'($urandom);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) zero_check(k);
        @(negedge clk); rst_n = 1;

        // abort after the 5th handshake, then restart from the base address
        @(posedge clk); #1;
        halt[1] = 1;
        out_ready[1] = 1;
        for (int c = 0; c < 100 && got[1].size() < 5; c++) begin
            @(posedge clk); #1;
            halt[1] = 0;
        end
        chk("five_bytes", 1, got[1].size(), 5);
        rst_n = 0;
        #1;
        zero_check(1);
        out_ready[1] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        run(1, 1, 1'b1, 2000);
        check_seq(1);

        run(0, 0, 1'b0, 100);
        check_seq(0);
        chk("sum_0a", 0, checksum[0], 16'h000A);
        for (int i = 1; i < hs[0].size(); i++) chk("spacing", 0, hs[0][i] - hs[0][i - 1], 3);
        idle_halt(0);
        idle_halt(1);

        @(posedge clk); #1;
        halt[2] = 1;
        @(posedge clk); #1;
        halt[2] = 0;
        chk("zero_done", 2, done[2], 1);
        chk("zero_sum", 2, checksum[2], 0);
        idle_halt(2);
        chk("zero_reads", 2, rdcnt[2], 0);

        run(3, 2, 1'b1, 4000);
        check_seq(3);
        chk("sum_c738", 3, checksum[3], 16'hC738);

        run(4, 2, 1'b0, 200);
        check_seq(4);
        chk("wrap_reads", 4, rdcnt[4], 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
